// File: rtl/mem_chk_pkg.sv
// mem_chk_pkg: shared state and status types for the memory write checker
package mem_chk_pkg;
   typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} chk_state_e;
   typedef struct packed {
      logic done;
      logic pass;
      logic fail;
      logic timeout;
   } chk_status_t;
endpackage

// File: rtl/chk_timeout_ctr.sv
// chk_timeout_ctr: run-cycle timer; expired is high once TIMEOUT_CYC-1 run cycles have elapsed
module chk_timeout_ctr #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (clr) r_cnt <= '0;
      else if (en && !expired) r_cnt <= r_cnt + 1'b1;
   assign expired = r_cnt == TW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order checker of core data-memory writes against an expected table.
// Define MEM_CHK_IGNCNT_EN to enable the saturating ignored-write counter on ign_cnt.
module mem_write_checker
   import mem_chk_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_EXP     = 4,
   parameter int TIMEOUT_CYC = 1024,
   localparam int CNT_W      = $clog2(NUM_EXP + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      MemWrite,
   input  logic [ADDR_W-1:0]         DataAdr,
   input  logic [DATA_W-1:0]         WriteData,
   input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
   input  logic [NUM_EXP*DATA_W-1:0] exp_data,
   input  logic [ADDR_W-1:0]         ign_lo,
   input  logic [ADDR_W-1:0]         ign_hi,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic                      timeout,
   output logic [CNT_W-1:0]          match_cnt,
   output logic [ADDR_W-1:0]         fail_addr,
   output logic [DATA_W-1:0]         fail_data,
   output logic [15:0]               ign_cnt
);
   localparam int NT = 2 ** CNT_W;
   chk_state_e        r_state;
   chk_status_t       r_st;
   logic [CNT_W-1:0]  r_match_cnt;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [DATA_W-1:0] r_fail_data;
   logic [ADDR_W-1:0] w_ea [NT];
   logic [DATA_W-1:0] w_ed [NT];
   logic              w_run, w_ign, w_chk, w_hit, w_fin, w_exp;
   // Table padded to a power of two so the match counter indexes it exactly
   for (genvar g = 0; g < NT; g++) begin : g_tbl
      if (g < NUM_EXP) begin : g_e
         assign w_ea[g] = exp_addr[g*ADDR_W +: ADDR_W];
         assign w_ed[g] = exp_data[g*DATA_W +: DATA_W];
      end else begin : g_z
         assign w_ea[g] = '0;
         assign w_ed[g] = '0;
      end
   end
   // Case-equality keeps X/Z on the bus from being skipped or matched
   assign w_run = r_state == RUN;
   assign w_ign = ((DataAdr >= ign_lo) && (DataAdr <= ign_hi)) === 1'b1;
   assign w_chk = w_run && MemWrite && !w_ign;
   assign w_hit = (DataAdr === w_ea[r_match_cnt]) && (WriteData === w_ed[r_match_cnt]);
   assign w_fin = r_match_cnt == CNT_W'(NUM_EXP - 1);
   chk_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk(clk), .reset(reset), .clr(start), .en(w_run), .expired(w_exp)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state     <= IDLE;
         r_st        <= '0;
         r_match_cnt <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else if (start) begin
         r_state     <= RUN;
         r_st        <= '0;
         r_match_cnt <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else if (w_run) begin
         if (w_chk && w_hit) r_match_cnt <= r_match_cnt + 1'b1;
         if (w_chk && !w_hit) begin
            r_state     <= FAIL;
            r_st        <= '{1'b1, 1'b0, 1'b1, 1'b0};
            r_fail_addr <= DataAdr;
            r_fail_data <= WriteData;
         end else if (w_chk && w_fin) begin
            r_state <= PASS;
            r_st    <= '{1'b1, 1'b1, 1'b0, 1'b0};
         end else if (w_exp) begin
            r_state <= TIMEOUT;
            r_st    <= '{1'b1, 1'b0, 1'b0, 1'b1};
         end
      end
   assign {done, pass, fail, timeout} = r_st;
   assign match_cnt = r_match_cnt;
   assign fail_addr = r_fail_addr;
   assign fail_data = r_fail_data;
`ifdef MEM_CHK_IGNCNT_EN
   logic [15:0] r_ign_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_ign_cnt <= '0;
      else if (start) r_ign_cnt <= '0;
      else if (w_run && MemWrite && w_ign && r_ign_cnt != '1) r_ign_cnt <= r_ign_cnt + 1'b1;
   assign ign_cnt = r_ign_cnt;
`else
   assign ign_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed and randomized checks against a behavioural run model
module tb_mem_write_checker;
   localparam int NE = 2;
   localparam int TO = 16;
   logic        clk = 0, reset = 1, start = 0, MemWrite = 0;
   logic [31:0] DataAdr = 0, WriteData = 0, ign_lo = 0, ign_hi = 0;
   logic [63:0] exp_addr, exp_data;
   logic        done, pass, fail, timeout;
   logic [1:0]  match_cnt;
   logic [31:0] fail_addr, fail_data;
   logic [15:0] ign_cnt;
   int n_tests = 0, n_fail = 0;
   int unsigned ea [NE], ed [NE];
   // Model: 0 idle, 1 running, 2 passed, 3 failed, 4 timed out
   int m_st, m_cnt, m_t, m_ign;
   int unsigned m_fa, m_fd;

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(NE), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .exp_addr(exp_addr), .exp_data(exp_data), .ign_lo(ign_lo),
      .ign_hi(ign_hi), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data), .ign_cnt(ign_cnt)
   );
   always #5 clk = ~clk;
   assign exp_addr = {ea[1], ea[0]};
   assign exp_data = {ed[1], ed[0]};

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_t = 0; m_ign = 0; m_fa = 0; m_fd = 0;
   endtask

   task automatic model_step();
      bit ign, decided;
      if (start) begin
         m_st = 1; m_cnt = 0; m_t = 0; m_ign = 0; m_fa = 0; m_fd = 0;
      end else if (m_st == 1) begin
         ign = DataAdr >= ign_lo && DataAdr <= ign_hi;
         decided = 0;
         if (MemWrite && ign && m_ign < 65535) m_ign++;
         if (MemWrite && !ign) begin
            decided = 1;
            if (DataAdr == ea[m_cnt] && WriteData == ed[m_cnt]) begin
               m_cnt++;
               if (m_cnt == NE) m_st = 2; else decided = 0;
            end else begin
               m_st = 3; m_fa = DataAdr; m_fd = WriteData;
            end
         end
         if (!decided) begin
            m_t++;
            if (m_t == TO) m_st = 4;
         end
      end
   endtask

   task automatic check_all();
      int exp_ign;
`ifdef MEM_CHK_IGNCNT_EN
      exp_ign = m_ign;
`else
      exp_ign = 0;
`endif
      check("done", done, 64'(m_st >= 2));
      check("pass", pass, 64'(m_st == 2));
      check("fail", fail, 64'(m_st == 3));
      check("timeout", timeout, 64'(m_st == 4));
      check("match_cnt", match_cnt, 64'(m_cnt));
      check("fail_addr", fail_addr, 64'(m_fa));
      check("fail_data", fail_data, 64'(m_fd));
      check("ign_cnt", ign_cnt, 64'(exp_ign));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_start();
      start = 1; cyc(); start = 0;
   endtask

   task automatic wr(input int unsigned a, input int unsigned d);
      MemWrite = 1; DataAdr = a; WriteData = d; cyc(); MemWrite = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      model_reset();
      ea[0] = 100; ea[1] = 104; ed[0] = 7; ed[1] = 9;
      ign_lo = 96; ign_hi = 96;
      #12;
      check_all();
      reset = 0;
      idle(2);
      wr(100, 7);
      check("idle_write_ignored", match_cnt, 0);
      // program order
      do_start();
      wr(96, $urandom);
      wr(100, 7);
      check("po_mid_pass", pass, 0);
      wr(104, 9);
      check("po_pass", pass, 1);
      check("po_cnt", match_cnt, 2);
      wr(100, 3);
      idle(2);
      // mismatch, with a same-cycle write on start that must not be checked
      start = 1; MemWrite = 1; DataAdr = 55; WriteData = 1; cyc(); start = 0; MemWrite = 0;
      check("start_write_unchecked", fail, 0);
      wr(100, 7);
      wr(104, 8);
      check("mm_fail", fail, 1);
      check("mm_addr", fail_addr, 104);
      check("mm_data", fail_data, 8);
      check("mm_nopass", pass, 0);
      // ignore window
      ign_hi = 97;
      do_start();
      wr(96, 1); wr(97, 2); wr(100, 7); wr(104, 9);
      check("ign_pass", pass, 1);
      // timeout exactly TO cycles after start
      do_start();
      idle(TO - 1);
      check("to_early", timeout, 0);
      idle(1);
      check("to_hit", timeout, 1);
      idle(3);
      // final match on expiry cycle wins
      do_start();
      idle(4);
      wr(100, 7);
      idle(TO - 6);
      wr(104, 9);
      check("prio_pass", pass, 1);
      check("prio_to", timeout, 0);
      // asynchronous reset mid-run
      do_start();
      wr(100, 7);
      #3 reset = 1;
      #1 model_reset();
      check_all();
      check("rst_cnt", match_cnt, 0);
      #1 reset = 0;
      idle(3);
      // randomized runs
      for (int s = 0; s < 12; s++) begin
         for (int i = 0; i < NE; i++) begin
            ea[i] = 90 + $urandom_range(0, 20);
            ed[i] = $urandom_range(0, 3);
         end
         ign_lo = 90 + $urandom_range(0, 20);
         ign_hi = ($urandom_range(0, 3) == 0) ? ign_lo - 1 : ign_lo + $urandom_range(0, 3);
         do_start();
         for (int c = 0; c < 24; c++) begin
            start = $urandom_range(0, 40) == 0;
            MemWrite = $urandom_range(0, 1);
            if (m_cnt < NE && $urandom_range(0, 2) != 0) begin
               DataAdr = ea[m_cnt];
               WriteData = ($urandom_range(0, 4) != 0) ? ed[m_cnt] : $urandom_range(0, 3);
            end else begin
               DataAdr = 90 + $urandom_range(0, 20);
               WriteData = $urandom_range(0, 3);
            end
            cyc();
         end
         start = 0; MemWrite = 0;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
